// File: rtl/lane_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : lane_rr_arbiter
//  Description : Round-robin arbiter sharing one downstream consumer among
//                NUM_LANES burst-carrying lanes. Grant is held for a whole
//                burst (or until MAX_BURST beats). One registered output
//                stage, tagged with the source lane index.
//  Revision    : 1.0 - initial release
// ============================================================================
module lane_rr_arbiter #(
    parameter int NUM_LANES = 3,
    parameter int DW        = 8,
    parameter int MAX_BURST = 16,
    localparam int LW       = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_LANES-1:0]    req_valid,
    input  logic [NUM_LANES*DW-1:0] req_data,
    input  logic [NUM_LANES-1:0]    req_last,
    output logic [NUM_LANES-1:0]    req_ready,
    output logic                    out_valid,
    output logic [DW-1:0]           out_data,
    output logic                    out_last,
    output logic [LW-1:0]           out_lane,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    err_burst
);

    localparam int CW = $clog2(MAX_BURST + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_LOCK = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [LW-1:0] ptr_q, ptr_d;
    logic [LW-1:0] gnt_q, gnt_d;
    logic [CW-1:0] beat_cnt_q, beat_cnt_d;
    logic          err_q, err_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          out_last_q, out_last_d;
    logic [LW-1:0] out_lane_q, out_lane_d;

    logic          w_take;
    logic          w_found;
    logic [LW-1:0] w_winner;
    logic [LW-1:0] w_sel_lane;
    logic          w_accept;
    logic [DW-1:0] w_beat_data;
    logic          w_beat_last;
    logic          w_forced;
    logic [LW-1:0] w_ptr_inc;

    // Output stage can take a new beat when empty or draining this cycle
    assign w_take = out_ready | ~out_valid_q;

    // Rotating priority search starting at ptr, wrapping modulo NUM_LANES
    always_comb begin
        logic [LW:0] cand;
        cand     = '0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            cand = {1'b0, ptr_q} + (LW+1)'(k);
            if (cand >= (LW+1)'(NUM_LANES)) begin
                cand = cand - (LW+1)'(NUM_LANES);
            end
            if (!w_found && req_valid[cand[LW-1:0]]) begin
                w_found  = 1'b1;
                w_winner = cand[LW-1:0];
            end
        end
    end

    // FSM output process: per-lane ready and the lane currently being steered
    always_comb begin
        req_ready  = '0;
        w_sel_lane = w_winner;
        if (rst_n) begin
            case (state_q)
                S_IDLE: begin
                    if (w_found && w_take) begin
                        req_ready[w_winner] = 1'b1;
                    end
                end
                default: begin
                    w_sel_lane         = gnt_q;
                    req_ready[gnt_q]   = w_take;
                end
            endcase
        end
    end

    // Beat mux from the steered lane; release pointer wraps past the last lane
    always_comb begin
        w_beat_data = '0;
        w_beat_last = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (w_sel_lane == LW'(i)) begin
                w_beat_data = req_data[i*DW +: DW];
                w_beat_last = req_last[i];
            end
        end
        if (w_sel_lane == LW'(NUM_LANES - 1)) begin
            w_ptr_inc = '0;
        end else begin
            w_ptr_inc = w_sel_lane + 1'b1;
        end
    end

    assign w_accept = |(req_ready & req_valid);
    // Beat being accepted is number beat_cnt_q+1; cap it at MAX_BURST
    assign w_forced = (state_q == S_LOCK) && w_accept && !w_beat_last &&
                      (beat_cnt_q == CW'(MAX_BURST - 1));

    // FSM next-state process: burst tracking, pointer advance, error flag
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_beat_last) begin
                        ptr_d = w_ptr_inc;
                    end else begin
                        state_d    = S_LOCK;
                        gnt_d      = w_winner;
                        beat_cnt_d = CW'(1);
                    end
                end
            end
            default: begin
                if (w_accept) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (w_beat_last || w_forced) begin
                        state_d    = S_IDLE;
                        ptr_d      = w_ptr_inc;
                        beat_cnt_d = '0;
                    end
                    if (w_forced) begin
                        err_d = 1'b1;
                    end
                end
            end
        endcase
    end

    // Output register next value: load on accept, drain on out_ready, else hold
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_lane_d  = out_lane_q;
        if (w_accept) begin
            out_valid_d = 1'b1;
            out_data_d  = w_beat_data;
            out_last_d  = w_beat_last | w_forced;
            out_lane_d  = w_sel_lane;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Arbitration bookkeeping and output stage registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            gnt_q       <= '0;
            beat_cnt_q  <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_lane_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            beat_cnt_q  <= beat_cnt_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_lane_q  <= out_lane_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_lane  = out_lane_q;
    assign busy      = (state_q == S_LOCK);
    assign err_burst = err_q;

endmodule
`default_nettype wire
